// File: rtl/spi_slave_rx.sv
// -----------------------------------------------------------------------------
// spi_slave_rx
//   SPI slave that receives one 32-bit frame per chip-select window (24-bit
//   payload + CRC-8, MSB first) and sends a response frame (tx_data + its
//   CRC-8) on miso. All SPI pins are asynchronous and are synchronized into
//   clk before any edge detection. Received results are presented on a
//   valid/ready interface; a completed frame that cannot be delivered is
//   dropped and flagged on overrun.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   sck        in   SPI clock (async, idle low)
//   csn        in   SPI chip select, active low (async)
//   mosi       in   master-out data (async)
//   miso       out  slave-out data
//   tx_data    in   [23:0] response payload, captured at frame start
//   rx_data    out  [23:0] received payload
//   rx_crc_ok  out  received CRC matches CRC over rx_data
//   rx_valid   out  rx_data / rx_crc_ok are valid
//   rx_ready   in   consumer accepts the current result
//   overrun    out  one-cycle pulse, completed frame dropped
//   frame_err  out  one-cycle pulse, csn rose before 32 bits
//
// FSM states
//   state | meaning
//   IDLE  | waiting for a csn falling edge
//   SHIFT | frame in progress, sampling mosi / driving miso
//   DONE  | 32 bits received, ignoring sck until csn rises
// -----------------------------------------------------------------------------
module spi_slave_rx #(
  parameter logic [7:0] CRC_POLY    = 8'h1D,
  parameter logic [7:0] CRC_INIT    = 8'hFF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sck,
  input  logic        csn,
  input  logic        mosi,
  output logic        miso,
  input  logic [23:0] tx_data,
  output logic [23:0] rx_data,
  output logic        rx_crc_ok,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        overrun,
  output logic        frame_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [5:0] BITS_FRAME   = 6'd32;
  localparam logic [5:0] BITS_PAYLOAD = 6'd24;
  localparam logic [3:0] FILL_DONE    = 4'(SYNC_STAGES);

  function automatic logic [7:0] crc_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
  endfunction

  // ---------------------------------------------------------------------------
  // Synchronizers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sck_sync_q, csn_sync_q, mosi_sync_q;
  logic                   sck_prev_q, csn_prev_q;
  logic                   sck_s, csn_s, mosi_s;
  logic                   sck_rise, sck_fall, csn_rise, csn_fall;

  // After reset the csn chain holds its reset value (1) until real samples
  // have propagated through it. armed_q only sets once a genuine high csn has
  // been seen, so a master still holding csn low across reset cannot start a
  // frame halfway through its transfer.
  logic [3:0] fill_cnt_q, fill_cnt_d;
  logic       armed_q, armed_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q  <= '0;
      csn_sync_q  <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      csn_prev_q  <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], csn};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sck_prev_q  <= sck_s;
      csn_prev_q  <= csn_s;
    end
  end

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign csn_s  = csn_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign csn_rise = csn_s & ~csn_prev_q;
  assign csn_fall = ~csn_s & csn_prev_q & armed_q;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;
  logic [5:0] bit_cnt_q, bit_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  logic cnt_full;
  assign cnt_full = (bit_cnt_q == BITS_FRAME);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (csn_fall) state_d = SHIFT;
      SHIFT: begin
        // A frame that completes in the same cycle csn rises is still good;
        // the rising edge is consumed here, so go straight back to IDLE.
        if (cnt_full)      state_d = csn_rise ? IDLE : DONE;
        else if (csn_rise) state_d = IDLE;
      end
      DONE:    if (csn_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and datapath strobes
  // ---------------------------------------------------------------------------
  logic start_frame, sample_en, drive_en, complete, abort;
  logic miso_q, miso_d;

  always_comb begin
    start_frame = 1'b0;
    sample_en   = 1'b0;
    drive_en    = 1'b0;
    complete    = 1'b0;
    abort       = 1'b0;
    miso        = 1'b0;
    case (state_q)
      IDLE:  start_frame = csn_fall;
      SHIFT: begin
        sample_en = sck_fall & ~cnt_full;
        drive_en  = sck_rise;
        complete  = cnt_full;
        abort     = csn_rise & ~cnt_full;
        miso      = miso_q & ~csn_s;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  logic [31:0] rx_shift_q, rx_shift_d;
  logic [7:0]  rx_crc_q, rx_crc_d;
  logic [23:0] tx_shift_q, tx_shift_d;
  logic [7:0]  tx_crc_q, tx_crc_d;
  logic [5:0]  tx_cnt_q, tx_cnt_d;
  logic [23:0] rx_data_q, rx_data_d;
  logic        rx_crc_ok_q, rx_crc_ok_d;
  logic        rx_valid_q, rx_valid_d;
  logic        overrun_q, overrun_d;
  logic        frame_err_q, frame_err_d;
  logic        accept;

  assign accept = rx_valid_q & rx_ready;

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    rx_crc_d    = rx_crc_q;
    tx_shift_d  = tx_shift_q;
    tx_crc_d    = tx_crc_q;
    tx_cnt_d    = tx_cnt_q;
    miso_d      = miso_q;
    rx_data_d   = rx_data_q;
    rx_crc_ok_d = rx_crc_ok_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = 1'b0;
    frame_err_d = 1'b0;
    fill_cnt_d  = (fill_cnt_q != FILL_DONE) ? fill_cnt_q + 4'd1 : fill_cnt_q;
    armed_d     = armed_q | ((fill_cnt_q == FILL_DONE) & csn_s);

    if (start_frame) begin
      bit_cnt_d  = '0;
      tx_cnt_d   = '0;
      rx_shift_d = '0;
      tx_shift_d = tx_data;
      rx_crc_d   = CRC_INIT;
      tx_crc_d   = CRC_INIT;
      miso_d     = 1'b0;
    end

    if (sample_en) begin
      rx_shift_d = {rx_shift_q[30:0], mosi_s};
      bit_cnt_d  = bit_cnt_q + 6'd1;
      if (bit_cnt_q < BITS_PAYLOAD) rx_crc_d = crc_step(rx_crc_q, mosi_s);
    end

    // Payload bits feed the tx CRC as they go out; once all 24 are sent the
    // CRC register itself becomes the shift source.
    if (drive_en) begin
      if (tx_cnt_q < BITS_PAYLOAD) begin
        miso_d     = tx_shift_q[23];
        tx_shift_d = {tx_shift_q[22:0], 1'b0};
        tx_crc_d   = crc_step(tx_crc_q, tx_shift_q[23]);
      end else if (tx_cnt_q < BITS_FRAME) begin
        miso_d   = tx_crc_q[7];
        tx_crc_d = {tx_crc_q[6:0], 1'b0};
      end else begin
        miso_d = 1'b0;
      end
      if (tx_cnt_q != BITS_FRAME) tx_cnt_d = tx_cnt_q + 6'd1;
    end

    // An accept in the completion cycle frees the output slot, so the new
    // result replaces the old one without an overrun.
    if (complete) begin
      if (!rx_valid_q || accept) begin
        rx_data_d   = rx_shift_q[31:8];
        rx_crc_ok_d = (rx_shift_q[7:0] == rx_crc_q);
        rx_valid_d  = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (accept) begin
      rx_valid_d = 1'b0;
    end

    if (abort) frame_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      rx_crc_q    <= CRC_INIT;
      tx_shift_q  <= '0;
      tx_crc_q    <= CRC_INIT;
      tx_cnt_q    <= '0;
      miso_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_crc_ok_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      fill_cnt_q  <= '0;
      armed_q     <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      rx_crc_q    <= rx_crc_d;
      tx_shift_q  <= tx_shift_d;
      tx_crc_q    <= tx_crc_d;
      tx_cnt_q    <= tx_cnt_d;
      miso_q      <= miso_d;
      rx_data_q   <= rx_data_d;
      rx_crc_ok_q <= rx_crc_ok_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      fill_cnt_q  <= fill_cnt_d;
      armed_q     <= armed_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_crc_ok = rx_crc_ok_q;
  assign rx_valid  = rx_valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_rx
//   Bit-banged SPI master driving spi_slave_rx, with a small transaction-level
//   model of the receive handshake and a CRC-8 reference function.
// -----------------------------------------------------------------------------
module tb_spi_slave_rx;

  localparam int HALF = 8;   // sck half period in clk cycles

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sck = 1'b0;
  logic        csn = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic [23:0] tx_data = '0;
  logic [23:0] rx_data;
  logic        rx_crc_ok;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic        overrun;
  logic        frame_err;

  spi_slave_rx dut (
    .clk       (clk),
    .rst       (rst),
    .sck       (sck),
    .csn       (csn),
    .mosi      (mosi),
    .miso      (miso),
    .tx_data   (tx_data),
    .rx_data   (rx_data),
    .rx_crc_ok (rx_crc_ok),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // CRC-8, poly 0x1D, seed 0xFF, payload MSB first
  function automatic logic [7:0] crc8(input logic [23:0] d);
    int c;
    c = 255;
    for (int i = 23; i >= 0; i--) begin
      int b;
      b = ((c >> 7) & 1) ^ int'(d[i]);
      c = (c << 1) & 255;
      if (b != 0) c = c ^ 29;
    end
    return 8'(c);
  endfunction

  // Pulse counters and accepted-result queue
  int ovr_cnt = 0;
  int ferr_cnt = 0;
  logic [24:0] got_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (overrun)   ovr_cnt++;
      if (frame_err) ferr_cnt++;
      if (rx_valid && rx_ready) got_q.push_back({rx_crc_ok, rx_data});
    end
  end

  // Transaction-level model of the result slot
  int          exp_ovr = 0;
  int          exp_ferr = 0;
  bit          m_pend = 0;
  logic [23:0] m_data = '0;
  logic        m_ok = 1'b0;

  task automatic model_frame(input logic [31:0] w, input bit ready);
    if (m_pend && !ready) begin
      exp_ovr++;
    end else begin
      m_data = w[31:8];
      m_ok   = (w[7:0] == crc8(w[31:8]));
      m_pend = !ready;
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Master transfer: nbits bits, optional reset pulse before bit rst_at.
  // tx_data is scrambled after the first bit to prove it was captured at start.
  task automatic spi_xfer(input logic [31:0] w, input int nbits, input int rst_at,
                          output logic [31:0] mw);
    mw = '0;
    csn = 1'b0;
    wait_clks(HALF);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        wait_clks(2);
        rst = 1'b0;
        return;
      end
      sck = 1'b1;
      mosi = w[31-i];
      wait_clks(HALF);
      if (i == 0) tx_data = ~tx_data;
      mw[31-i] = miso;
      sck = 1'b0;
      wait_clks(HALF);
    end
    csn = 1'b1;
    mosi = 1'b0;
    wait_clks(HALF);
  endtask

  task automatic ack();
    rx_ready = 1'b1;
    wait_clks(1);
    rx_ready = 1'b0;
    m_pend = 0;
  endtask

  task automatic check_slot(input string tag);
    check_val({tag, "_valid"}, 32'(rx_valid), 32'(m_pend));
    if (m_pend) begin
      check_val({tag, "_data"}, 32'(rx_data), 32'(m_data));
      check_val({tag, "_crc_ok"}, 32'(rx_crc_ok), 32'(m_ok));
    end
  endtask

  initial begin
    logic [31:0] mw, w;
    logic [23:0] tx;

    // Reset state
    wait_clks(5);
    check_val("rst_miso", 32'(miso), 0);
    check_val("rst_rx_data", 32'(rx_data), 0);
    check_val("rst_crc_ok", 32'(rx_crc_ok), 0);
    check_val("rst_valid", 32'(rx_valid), 0);
    check_val("rst_flags", {30'd0, overrun, frame_err}, 0);
    rst = 1'b0;
    wait_clks(10);

    // Good frame, zero response
    tx_data = 24'h000000;
    spi_xfer(32'h0000000E, 32, -1, mw);
    model_frame(32'h0000000E, 0);
    check_val("good_miso", mw, 32'h0000000E);
    check_val("good_data", 32'(rx_data), 0);
    check_val("good_crc_ok", 32'(rx_crc_ok), 1);
    check_slot("good");
    wait_clks(20);
    check_val("good_hold", 32'(rx_valid), 1);
    check_val("idle_miso", 32'(miso), 0);
    ack();
    check_val("good_ack", 32'(rx_valid), 0);

    // Bad CRC, response with non-trivial payload
    tx_data = 24'hA5A5A5;
    spi_xfer(32'h0000000F, 32, -1, mw);
    model_frame(32'h0000000F, 0);
    check_val("bad_crc_ok", 32'(rx_crc_ok), 0);
    check_slot("bad");
    check_val("a5_miso", mw, {24'hA5A5A5, crc8(24'hA5A5A5)});
    ack();

    // Overrun: two frames, nothing consumed
    w = {24'h123456, crc8(24'h123456)};
    spi_xfer(w, 32, -1, mw);
    model_frame(w, 0);
    w = {24'hABCDEF, crc8(24'hABCDEF)};
    spi_xfer(w, 32, -1, mw);
    model_frame(w, 0);
    check_val("ovr_count", 32'(ovr_cnt), 32'(exp_ovr));
    check_slot("ovr_hold");
    ack();

    // Same, but the consumer is ready while the second frame completes
    w = {24'h0F0F0F, crc8(24'h0F0F0F)};
    spi_xfer(w, 32, -1, mw);
    model_frame(w, 0);
    rx_ready = 1'b1;
    m_pend = 0;
    w = {24'h777777, crc8(24'h777777)};
    spi_xfer(w, 32, -1, mw);
    model_frame(w, 1);
    rx_ready = 1'b0;
    check_val("no_ovr_count", 32'(ovr_cnt), 32'(exp_ovr));
    check_slot("no_ovr");

    // Abort after 13 bits with a result pending
    w = {24'h5A5A5A, crc8(24'h5A5A5A)};
    spi_xfer(w, 32, -1, mw);
    model_frame(w, 0);
    spi_xfer(32'hFFFFFFFF, 13, -1, mw);
    exp_ferr++;
    check_val("abort_ferr", 32'(ferr_cnt), 32'(exp_ferr));
    check_slot("abort_hold");
    ack();
    w = {24'hC0FFEE, crc8(24'hC0FFEE)};
    spi_xfer(w, 32, -1, mw);
    model_frame(w, 0);
    check_slot("after_abort");

    // Reset mid-frame at bit 20, with a result pending
    spi_xfer(32'hDEADBEEF, 32, 20, mw);
    m_pend = 0;
    check_val("mrst_valid", 32'(rx_valid), 0);
    check_val("mrst_data", 32'(rx_data), 0);
    check_val("mrst_crc_ok", 32'(rx_crc_ok), 0);
    check_val("mrst_miso", 32'(miso), 0);
    check_val("mrst_flags", {30'd0, overrun, frame_err}, 0);
    wait_clks(10);
    csn = 1'b1;
    wait_clks(10);
    check_val("mrst_no_ferr", 32'(ferr_cnt), 32'(exp_ferr));
    tx_data = 24'h000000;
    spi_xfer(32'h0000000E, 32, -1, mw);
    model_frame(32'h0000000E, 0);
    check_slot("mrst_next");
    check_val("mrst_next_miso", mw, 32'h0000000E);
    ack();

    // Randomized frames, consumer always ready
    got_q.delete();
    rx_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      w[31:8] = 24'($urandom);
      w[7:0]  = crc8(w[31:8]);
      if ($urandom_range(0, 2) == 0) w[7:0] = w[7:0] ^ 8'($urandom_range(1, 255));
      tx = 24'($urandom);
      tx_data = tx;
      spi_xfer(w, 32, -1, mw);
      model_frame(w, 1);
      check_val("rand_miso", mw, {tx, crc8(tx)});
      for (int k = 0; k < 100 && got_q.size() == 0; k++) wait_clks(1);
      check_val("rand_resp_cnt", 32'(got_q.size()), 1);
      if (got_q.size() > 0) check_val("rand_resp", 32'(got_q.pop_front()), 32'({m_ok, m_data}));
      got_q.delete();
    end
    rx_ready = 1'b0;
    check_val("final_ovr", 32'(ovr_cnt), 32'(exp_ovr));
    check_val("final_ferr", 32'(ferr_cnt), 32'(exp_ferr));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx.md
SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter: CRC_POLY, 8'h1D, CRC-8 SAE-J1850 polynomial.
REQ-003 Parameter: CRC_INIT, 8'hFF, CRC register seed at frame start.
REQ-004 Parameter: SYNC_STAGES, 2, flop count of each input synchronizer (minimum 2).
REQ-005 Port: clk  input  1  system clock; all logic is on the rising edge.
REQ-006 Port: rst  input  1  synchronous active-high reset.
REQ-007 Port: sck  input  1  SPI clock from master, asynchronous to clk.
REQ-008 Port: csn  input  1  SPI chip select, active low, asynchronous.
REQ-009 Port: mosi  input  1  master-out data, asynchronous.
REQ-010 Port: miso  output  1  slave-out data.
REQ-011 Port: tx_data  input  24  response payload, captured at frame start.
REQ-012 Port: rx_data  output  24  received payload.
REQ-013 Port: rx_crc_ok  output  1  received CRC matches the CRC computed over rx_data.
REQ-014 Port: rx_valid  output  1  rx_data and rx_crc_ok are valid.
REQ-015 Port: rx_ready  input  1  consumer accepts the current result.
REQ-016 Port: overrun  output  1  one-cycle pulse when a completed frame is dropped.
REQ-017 Port: frame_err  output  1  one-cycle pulse when csn rises mid-frame.

Function
REQ-018 sck, csn and mosi SHALL each pass through a SYNC_STAGES flop synchronizer before use; edge detection SHALL use the synchronized values only.
REQ-019 Supported sck frequency SHALL be at most clk/8.
REQ-020 Frame format: 32 bits, MSB first; bits 31..8 are payload and bits 7..0 are CRC.
REQ-021 SPI timing:
  - master drives mosi on sck rising edge and samples miso on sck falling edge;
  - slave samples mosi on the synchronized sck falling edge;
  - slave updates miso on the synchronized sck rising edge.
REQ-022 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-023 IDLE to SHIFT: on the synchronized csn falling edge.
  - clear the bit counter to 0;
  - load the tx shift register with tx_data;
  - seed both rx and tx CRC registers with CRC_INIT.
REQ-024 In SHIFT, each sampled falling edge SHALL shift mosi into rx_shift[31:0] and increment a 6-bit counter.
  - For counts 0..23 the sampled bit SHALL also update the rx CRC: fb = crc[7]^bit; crc = (crc<<1) ^ (fb ? CRC_POLY : 0).
REQ-025 miso bit ordering:
  - miso SHALL present tx bit 31 from the first rising edge of the frame;
  - each subsequent rising edge SHALL advance one bit;
  - after 24 payload bits, miso SHALL send the tx CRC MSB first; the tx CRC is computed over tx_data with the same algorithm.
REQ-026 SHIFT to DONE: when the counter reaches 32, latch the result.
  - If rx_valid=0: rx_data <= rx_shift[31:8]; rx_crc_ok <= (rx_shift[7:0] == rx CRC); rx_valid <= 1 on the next clk.
  - If rx_valid=1: the frame SHALL be dropped, rx_data is held, and overrun SHALL pulse for 1 cycle.
REQ-027 In DONE, further sck edges SHALL be ignored and miso SHALL be 0. DONE to IDLE: on the synchronized csn rising edge.
REQ-028 In SHIFT, a csn rising edge with counter < 32 SHALL:
  - discard the frame;
  - pulse frame_err for 1 cycle;
  - return to IDLE;
  - leave rx_valid unchanged.
REQ-029 Handshake:
  - rx_valid SHALL stay high until a cycle with rx_valid & rx_ready, then fall on the next clk;
  - rx_data SHALL be stable while rx_valid=1;
  - if an accept and a new frame completion occur in the same cycle, the new result SHALL be latched, rx_valid SHALL remain 1, and no overrun SHALL occur.
REQ-030 miso SHALL be 0 whenever synchronized csn is high.

Reset
REQ-031 While rst=1 at a clk rising edge:
  - state=IDLE and counter=0;
  - synchronizers SHALL be set to sck=0, csn=1, mosi=0;
  - miso=0, rx_data=0, rx_crc_ok=0, rx_valid=0, overrun=0, frame_err=0.
REQ-032 Reset asserted mid-frame SHALL abort the frame without a frame_err pulse; the block SHALL wait for a fresh csn falling edge after reset release.

Verification
REQ-033 Good frame: mosi=0x0000000E, rx_ready=0 -> rx_data=0x000000, rx_crc_ok=1, rx_valid=1 held until rx_ready=1.
REQ-034 Bad CRC: mosi=0x0000000F -> rx_data=0x000000, rx_crc_ok=0, rx_valid=1.
REQ-035 Response path: tx_data=0x000000 -> master captures 0x0000000E on miso; tx_data=0xA5A5A5 -> master captures 0xA5A5A5 followed by the model-computed CRC.
REQ-036 Overrun: two good frames with rx_ready=0 -> first frame held, overrun pulses once at second completion; same test with rx_ready=1 at completion -> no overrun.
REQ-037 Abort: csn rises after 13 bits -> frame_err pulses once, rx_valid unchanged, next full frame received correctly.
REQ-038 Reset mid-frame: rst=1 for 2 cycles at bit 20 -> all outputs 0; a following frame 0x0000000E gives rx_crc_ok=1.
